// File: rtl/regfile_be_sb.sv
// rtl/regfile_be_sb.sv - register file with byte-enabled write, link port, bypass and busy scoreboard
module regfile_be_sb #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int LINK_REG = 31,
  localparam int AW      = $clog2(NREGS),
  localparam int NB      = DATA_W / 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [NB-1:0]           wbyteen,
  input  logic                    link_we,
  input  logic [DATA_W-1:0]       link_data,
  input  logic [NREAD*AW-1:0]     raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  input  logic                    busy_set,
  input  logic [AW-1:0]           busy_addr,
  output logic [NREAD-1:0]        rd_busy,
  output logic                    hazard,
  output logic [DATA_W-1:0]       register_v0
);

  localparam logic [AW:0]   ADDR_LIM = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LINK_A   = AW'(LINK_REG);
  localparam logic          ZERO_EN  = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_busy;

  logic              w_waddr_ok;
  logic              w_gen_commit;
  logic              w_link_commit;
  logic              w_gen_eff;
  logic [DATA_W-1:0] w_gen_cur;
  logic [DATA_W-1:0] w_gen_merged;

  // A general write only counts when at least one byte is enabled and it targets a real, writable register.
  assign w_waddr_ok    = ({1'b0, waddr} < ADDR_LIM) && !(ZERO_EN && (waddr == '0));
  assign w_gen_commit  = we && (|wbyteen) && w_waddr_ok;
  assign w_link_commit = link_we && !(ZERO_EN && (LINK_A == '0));
  // On a collision with the link port the link word replaces every byte, so the general write is dropped.
  assign w_gen_eff     = w_gen_commit && !(w_link_commit && (waddr == LINK_A));
  assign w_gen_cur     = ({1'b0, waddr} < ADDR_LIM) ? r_regs[waddr] : '0;

  // Byte-merge the incoming general write data over the current contents of the target.
  always_comb begin
    w_gen_merged = w_gen_cur;
    for (int b = 0; b < NB; b++) begin
      if (wbyteen[b]) w_gen_merged[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  // Register storage and busy scoreboard; a new busy_set beats a same-cycle clearing write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
      r_busy <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (w_link_commit && (LINK_A == AW'(r))) begin
          r_regs[r] <= link_data;
        end else if (w_gen_eff && (waddr == AW'(r))) begin
          r_regs[r] <= w_gen_merged;
        end
        if (busy_set && (busy_addr == AW'(r)) && !(ZERO_EN && (r == 0))) begin
          r_busy[r] <= 1'b1;
        end else if ((w_link_commit && (LINK_A == AW'(r))) ||
                     (w_gen_commit && (waddr == AW'(r)))) begin
          r_busy[r] <= 1'b0;
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NREAD; g++) begin : g_rd
      logic [AW-1:0]     w_ra;
      logic              w_inr;
      logic              w_zero;
      logic              w_hit_link;
      logic              w_hit_gen;
      logic [DATA_W-1:0] w_stored;
      logic              w_busy_st;

      assign w_ra       = raddr[g*AW +: AW];
      assign w_inr      = ({1'b0, w_ra} < ADDR_LIM);
      assign w_zero     = ZERO_EN && (w_ra == '0);
      assign w_hit_link = (BYPASS != 0) && w_link_commit && (w_ra == LINK_A);
      assign w_hit_gen  = (BYPASS != 0) && w_gen_commit && (w_ra == waddr);
      assign w_stored   = w_inr ? r_regs[w_ra] : '0;
      assign w_busy_st  = w_inr ? r_busy[w_ra] : 1'b0;

      // Bypass forwards the committing value; reads of the zero register and out-of-range addresses return 0.
      assign rdata[g*DATA_W +: DATA_W] = (w_zero || !w_inr) ? '0 :
                                         w_hit_link ? link_data :
                                         (w_hit_gen && w_gen_eff) ? w_gen_merged :
                                         w_stored;
      assign rd_busy[g] = !w_zero && w_busy_st && !w_hit_link && !w_hit_gen;
    end
  endgenerate

  assign hazard      = |rd_busy;
  assign register_v0 = r_regs[2];

endmodule

// File: tb/tb_regfile_be_sb.sv
// tb/tb_regfile_be_sb.sv - directed checks of regfile_be_sb with and without bypass
module tb_regfile_be_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wbyteen;
  logic        link_we;
  logic [31:0] link_data;
  logic [9:0]  raddr;
  logic        busy_set;
  logic [4:0]  busy_addr;

  logic [63:0] rdata_b, rdata_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic        hazard_b, hazard_n;
  logic [31:0] v0_b, v0_n;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  regfile_be_sb #(.BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wbyteen(wbyteen),
    .link_we(link_we), .link_data(link_data), .raddr(raddr), .rdata(rdata_b),
    .busy_set(busy_set), .busy_addr(busy_addr), .rd_busy(rd_busy_b), .hazard(hazard_b),
    .register_v0(v0_b)
  );

  regfile_be_sb #(.BYPASS(0)) u_nob (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wbyteen(wbyteen),
    .link_we(link_we), .link_data(link_data), .raddr(raddr), .rdata(rdata_n),
    .busy_set(busy_set), .busy_addr(busy_addr), .rd_busy(rd_busy_n), .hazard(hazard_n),
    .register_v0(v0_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we = 0; waddr = '0; wdata = '0; wbyteen = '0;
    link_we = 0; link_data = '0; busy_set = 0; busy_addr = '0;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    raddr = '0;
    reset = 1;
    edge_step();
    reset = 0;
    raddr = {5'd5, 5'd9};
    #3;
    chk("rst_rdata_b", rdata_b[31:0], 32'h0);
    chk("rst_rdata_n", rdata_n[63:32], 32'h0);
    chk("rst_hazard", {30'd0, hazard_b, hazard_n}, 32'h0);
    chk("rst_v0", v0_b, 32'h0);

    // full-word write to r5
    we = 1; waddr = 5'd5; wdata = 32'hDEADBEEF; wbyteen = 4'hF; raddr = {5'd0, 5'd5};
    #3;
    chk("t1_byp_same", rdata_b[31:0], 32'hDEADBEEF);
    chk("t1_nob_same", rdata_n[31:0], 32'h0);
    edge_step();
    idle();
    #1;
    chk("t1_nob_next", rdata_n[31:0], 32'hDEADBEEF);

    // partial byte write
    we = 1; waddr = 5'd5; wdata = 32'h11223344; wbyteen = 4'b0101;
    #3;
    chk("t2_byp_same", rdata_b[31:0], 32'hDE22BE44);
    chk("t2_nob_same", rdata_n[31:0], 32'hDEADBEEF);
    edge_step();
    idle();
    #1;
    chk("t2_nob_next", rdata_n[31:0], 32'hDE22BE44);

    // link collision on r31
    we = 1; waddr = 5'd31; wdata = 32'hAAAA0000; wbyteen = 4'hF;
    link_we = 1; link_data = 32'h00400008; raddr = {5'd0, 5'd31};
    #3;
    chk("t3_coll_byp", rdata_b[31:0], 32'h00400008);
    edge_step();
    idle();
    #1;
    chk("t3_coll_nob", rdata_n[31:0], 32'h00400008);

    // general write to r4 alongside link write
    we = 1; waddr = 5'd4; wdata = 32'h12345678; wbyteen = 4'hF;
    link_we = 1; link_data = 32'h00400010; raddr = {5'd31, 5'd4};
    #3;
    chk("t3_dual_byp_r4", rdata_b[31:0], 32'h12345678);
    chk("t3_dual_byp_r31", rdata_b[63:32], 32'h00400010);
    edge_step();
    idle();
    #1;
    chk("t3_dual_nob_r4", rdata_n[31:0], 32'h12345678);
    chk("t3_dual_nob_r31", rdata_n[63:32], 32'h00400010);

    // wbyteen=0 is a no-op
    we = 1; waddr = 5'd4; wdata = 32'hFFFFFFFF; wbyteen = 4'h0;
    #3;
    chk("be0_byp", rdata_b[31:0], 32'h12345678);
    edge_step();
    idle();
    #1;
    chk("be0_nob", rdata_n[31:0], 32'h12345678);

    // zero register ignores write and busy_set
    we = 1; waddr = 5'd0; wdata = 32'hFFFFFFFF; wbyteen = 4'hF;
    busy_set = 1; busy_addr = 5'd0; raddr = {5'd0, 5'd0};
    #3;
    chk("t4_byp_same", rdata_b[31:0], 32'h0);
    edge_step();
    idle();
    #1;
    chk("t4_rdata_b", rdata_b[63:32], 32'h0);
    chk("t4_rdata_n", rdata_n[31:0], 32'h0);
    chk("t4_hazard", {30'd0, hazard_b, hazard_n}, 32'h0);

    // scoreboard set and clear via write
    busy_set = 1; busy_addr = 5'd8;
    edge_step();
    idle();
    raddr = {5'd8, 5'd0};
    #1;
    chk("t5_busy_b", {30'd0, rd_busy_b}, 32'h2);
    chk("t5_busy_n", {30'd0, rd_busy_n}, 32'h2);
    chk("t5_hazard", {30'd0, hazard_b, hazard_n}, 32'h3);
    we = 1; waddr = 5'd8; wdata = 32'h5; wbyteen = 4'hF;
    #3;
    chk("t5_byp_clear_same", {30'd0, rd_busy_b}, 32'h0);
    chk("t5_nob_still", {30'd0, rd_busy_n}, 32'h2);
    edge_step();
    idle();
    #1;
    chk("t5_nob_clear_next", {30'd0, rd_busy_n}, 32'h0);
    chk("t5_hazard_after", {30'd0, hazard_b, hazard_n}, 32'h0);

    // a wbyteen=0 write does not clear busy
    busy_set = 1; busy_addr = 5'd10;
    edge_step();
    idle();
    we = 1; waddr = 5'd10; wdata = 32'h77; wbyteen = 4'h0; raddr = {5'd10, 5'd0};
    #3;
    chk("be0_busy_byp", {30'd0, rd_busy_b}, 32'h2);
    edge_step();
    idle();
    #1;
    chk("be0_busy_n", {30'd0, rd_busy_n}, 32'h2);

    // set wins over clear on r9
    busy_set = 1; busy_addr = 5'd9; we = 1; waddr = 5'd9; wdata = 32'h9; wbyteen = 4'hF;
    edge_step();
    idle();
    raddr = {5'd9, 5'd0};
    #1;
    chk("t6_setwin_b", {30'd0, rd_busy_b}, 32'h2);
    chk("t6_setwin_n", {30'd0, rd_busy_n}, 32'h2);
    chk("t6_r9_data", rdata_n[63:32], 32'h9);

    // register_v0 reflects stored r2 only
    we = 1; waddr = 5'd2; wdata = 32'hCAFEF00D; wbyteen = 4'hF;
    #3;
    chk("v0_same", v0_b, 32'h0);
    edge_step();
    idle();
    #1;
    chk("v0_next", v0_n, 32'hCAFEF00D);

    // reset with a write pending
    reset = 1; we = 1; waddr = 5'd3; wdata = 32'h33333333; wbyteen = 4'hF;
    edge_step();
    reset = 0;
    idle();
    raddr = {5'd9, 5'd5};
    #1;
    chk("t6_rst_r5", rdata_b[31:0], 32'h0);
    chk("t6_rst_r9", rdata_n[63:32], 32'h0);
    chk("t6_rst_hazard", {30'd0, hazard_b, hazard_n}, 32'h0);
    chk("t6_rst_v0", v0_b | v0_n, 32'h0);
    raddr = {5'd3, 5'd4};
    #1;
    chk("t6_rst_r3", rdata_n[63:32], 32'h0);
    chk("t6_rst_r4", rdata_n[31:0], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
